xge_wb_regs: RTL

Wishbone slave management register block for the 10GE MAC core. Responds to the Wishbone master, i.e. the host or the testbench driving `wb_cyc_i`/`wb_stb_i`. Holds the MAC configuration, latches core error/fault events into maskable interrupt-pending bits that drive `wb_int_o`, and optionally keeps TX/RX packet statistics counters. Sits in the Wishbone clock domain; core-side event pulses arrive already synchronized to `wb_clk_i`.

---
 rtl/xge_wb_regs_pkg.sv | 26 ++
 rtl/xge_wb_stat_counter.sv | 23 ++
 rtl/xge_wb_regs.sv | 138 +++++++++++++
 3 files changed

// File: rtl/xge_wb_regs_pkg.sv
// rtl/xge_wb_regs_pkg.sv - address map, event indices and reset values for the 10GE MAC register block
package xge_wb_regs_pkg;

  localparam int NUM_EVT = 8;

  localparam logic [7:0] ADDR_CONFIG       = 8'h00;
  localparam logic [7:0] ADDR_INT_PENDING  = 8'h08;
  localparam logic [7:0] ADDR_INT_STATUS   = 8'h0C;
  localparam logic [7:0] ADDR_INT_MASK     = 8'h10;
  localparam logic [7:0] ADDR_TX_PKT_COUNT = 8'h20;
  localparam logic [7:0] ADDR_RX_PKT_COUNT = 8'h24;

  localparam int EVT_TX_UNDERFLOW = 0;
  localparam int EVT_TX_OVERFLOW  = 1;
  localparam int EVT_RX_OVERFLOW  = 2;
  localparam int EVT_RX_CRC_ERR   = 3;
  localparam int EVT_RX_FRAG_ERR  = 4;
  localparam int EVT_LOCAL_FAULT  = 5;
  localparam int EVT_REMOTE_FAULT = 6;
  localparam int EVT_RX_PAD_ERR   = 7;

  localparam logic               CONFIG_TX_EN_RST = 1'b1;
  localparam logic [NUM_EVT-1:0] INT_PENDING_RST  = '0;
  localparam logic [NUM_EVT-1:0] INT_MASK_RST     = '0;

endpackage

// File: rtl/xge_wb_stat_counter.sv
// rtl/xge_wb_stat_counter.sv - 32-bit wrapping statistics counter with clear-over-increment priority
module xge_wb_stat_counter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inc,
  input  logic        i_clr,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  // Clear beats a coincident increment; increment wraps naturally at 2^32.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/xge_wb_regs.sv
// rtl/xge_wb_regs.sv - Wishbone management registers for the 10GE MAC; XGE_WB_STATS_EN adds packet counters
module xge_wb_regs
  import xge_wb_regs_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_int_o,
  output logic              cfg_tx_enable_o,
  input  logic [7:0]        evt_i,
  input  logic [1:0]        status_i,
  input  logic              tx_pkt_done_i,
  input  logic              rx_pkt_done_i
);

  logic               r_ack;
  logic [DATA_W-1:0]  r_dat;
  logic               r_int;
  logic               r_cfg_tx_en;
  logic [NUM_EVT-1:0] r_pend;
  logic [NUM_EVT-1:0] r_mask;

  logic               w_req;
  logic               w_wr;
  logic [ADDR_W-1:0]  w_adr;
  logic               w_sel_cfg;
  logic               w_sel_pend;
  logic               w_sel_stat;
  logic               w_sel_mask;
  logic [NUM_EVT-1:0] w_pend_clr;
  logic [NUM_EVT-1:0] w_pend_nxt;
  logic [DATA_W-1:0]  w_rd_data;
  logic               w_unused;

  // A new access starts only while no ack is out, so back-to-back strobes get one access per two cycles.
  assign w_req = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr  = w_req & wb_we_i;
  assign w_adr = {wb_adr_i[ADDR_W-1:2], 2'b00};

  assign w_sel_cfg  = (w_adr == ADDR_W'(ADDR_CONFIG));
  assign w_sel_pend = (w_adr == ADDR_W'(ADDR_INT_PENDING));
  assign w_sel_stat = (w_adr == ADDR_W'(ADDR_INT_STATUS));
  assign w_sel_mask = (w_adr == ADDR_W'(ADDR_INT_MASK));

  // New events are ORed in after the W1C mask so a coincident event keeps its bit set.
  assign w_pend_clr = (w_wr && w_sel_pend) ? wb_dat_i[NUM_EVT-1:0] : '0;
  assign w_pend_nxt = (r_pend & ~w_pend_clr) | evt_i;

`ifdef XGE_WB_STATS_EN
  logic        w_sel_tx_cnt;
  logic        w_sel_rx_cnt;
  logic [31:0] w_tx_cnt;
  logic [31:0] w_rx_cnt;

  assign w_sel_tx_cnt = (w_adr == ADDR_W'(ADDR_TX_PKT_COUNT));
  assign w_sel_rx_cnt = (w_adr == ADDR_W'(ADDR_RX_PKT_COUNT));

  xge_wb_stat_counter u_tx_cnt (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_inc   (tx_pkt_done_i),
    .i_clr   (w_wr & w_sel_tx_cnt),
    .o_count (w_tx_cnt)
  );

  xge_wb_stat_counter u_rx_cnt (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_inc   (rx_pkt_done_i),
    .i_clr   (w_wr & w_sel_rx_cnt),
    .o_count (w_rx_cnt)
  );

  assign w_unused = ^{wb_adr_i[1:0], wb_dat_i[DATA_W-1:NUM_EVT]};
`else
  assign w_unused = ^{wb_adr_i[1:0], wb_dat_i[DATA_W-1:NUM_EVT], tx_pkt_done_i, rx_pkt_done_i};
`endif

  // Read mux works on current register state, so a read returns values from before this edge's updates.
  always_comb begin
    w_rd_data = '0;
    if (w_sel_cfg) begin
      w_rd_data = DATA_W'(r_cfg_tx_en);
    end else if (w_sel_pend) begin
      w_rd_data = DATA_W'(r_pend);
    end else if (w_sel_stat) begin
      w_rd_data = DATA_W'(status_i);
    end else if (w_sel_mask) begin
      w_rd_data = DATA_W'(r_mask);
`ifdef XGE_WB_STATS_EN
    end else if (w_sel_tx_cnt) begin
      w_rd_data = DATA_W'(w_tx_cnt);
    end else if (w_sel_rx_cnt) begin
      w_rd_data = DATA_W'(w_rx_cnt);
`endif
    end
  end

  // Register state, ack/read-data pipeline and the registered interrupt level.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_int       <= 1'b0;
      r_cfg_tx_en <= CONFIG_TX_EN_RST;
      r_pend      <= INT_PENDING_RST;
      r_mask      <= INT_MASK_RST;
    end else begin
      r_ack <= w_req;
      if (w_req) begin
        r_dat <= w_rd_data;
      end
      if (w_wr && w_sel_cfg) begin
        r_cfg_tx_en <= wb_dat_i[0];
      end
      if (w_wr && w_sel_mask) begin
        r_mask <= wb_dat_i[NUM_EVT-1:0];
      end
      r_pend <= w_pend_nxt;
      r_int  <= |(r_pend & r_mask);
    end
  end

  assign wb_ack_o        = r_ack;
  assign wb_dat_o        = r_dat;
  assign wb_int_o        = r_int;
  assign cfg_tx_enable_o = r_cfg_tx_en;

endmodule
